maze_path_rle: RTL and testbench

MAZE_PATH_RLE -- requirements
Module: maze_path_rle

---
 rtl/maze_pkg.sv | 35 +++
 rtl/maze_path_rle_if.sv | 32 +++
 rtl/maze_pos_tracker.sv | 39 +++
 rtl/maze_path_rle.sv | 111 +++++++++++
 tb/tb_maze_path_rle.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze constants, direction codes, FSM states and position helpers
package maze_pkg;

    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_D = 2'd1;
    localparam logic [1:0] DIR_L = 2'd2;
    localparam logic [1:0] DIR_U = 2'd3;

    localparam int MAZE_DIM = 17;
    localparam int MAZE_MAX = MAZE_DIM - 1;

    localparam int RUN_W  = 5;
    localparam int STEP_W = 9;

    typedef logic signed [5:0] pos_t;

    localparam pos_t POS_MAX = pos_t'(MAZE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic pos_t pos_step(pos_t p, logic [1:0] dir, logic [1:0] inc, logic [1:0] dec);
        if (dir == inc) return p + pos_t'(1);
        if (dir == dec) return p - pos_t'(1);
        return p;
    endfunction

    function automatic logic in_bounds(pos_t p);
        return !p[5] && (p <= POS_MAX);
    endfunction

endpackage

// File: rtl/maze_path_rle_if.sv
// rtl/maze_path_rle_if.sv - step stream in, run stream out; out_steps exists only with MAZE_RLE_STEPCNT_EN
interface maze_path_rle_if;
    import maze_pkg::*;

    logic             in_valid;
    logic [1:0]       in;
    logic             out_valid;
    logic [1:0]       out_dir;
    logic [RUN_W-1:0] out_run;
    logic             out_last;
    logic             err;
`ifdef MAZE_RLE_STEPCNT_EN
    logic [STEP_W-1:0] out_steps;
`endif

    modport master (
        output in_valid, in,
`ifdef MAZE_RLE_STEPCNT_EN
        input  out_steps,
`endif
        input  out_valid, out_dir, out_run, out_last, err
    );

    modport slave (
        input  in_valid, in,
`ifdef MAZE_RLE_STEPCNT_EN
        output out_steps,
`endif
        output out_valid, out_dir, out_run, out_last, err
    );

endinterface

// File: rtl/maze_pos_tracker.sv
// rtl/maze_pos_tracker.sv - walks (row, col) along the path, latches bound violations, flags a bad endpoint
module maze_pos_tracker
    import maze_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       first,
    input  logic [1:0] dir,
    output logic       bad
);

    pos_t row_q, col_q, row_b, col_b, row_n, col_n;
    logic err_q, err_n;

    // The first step of a path starts from the origin with a clean error flag.
    always_comb begin
        row_b = first ? '0 : row_q;
        col_b = first ? '0 : col_q;
        row_n = pos_step(row_b, dir, DIR_D, DIR_U);
        col_n = pos_step(col_b, dir, DIR_R, DIR_L);
        err_n = (first ? 1'b0 : err_q) | !in_bounds(row_n) | !in_bounds(col_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            err_q <= 1'b0;
        end else if (step) begin
            row_q <= row_n;
            col_q <= col_n;
            err_q <= err_n;
        end
    end

    assign bad = err_q | (row_q != POS_MAX) | (col_q != POS_MAX);

endmodule

// File: rtl/maze_path_rle.sv
// rtl/maze_path_rle.sv - run-length encoder for 17x17 maze paths; MAZE_RLE_STEPCNT_EN adds out_steps
module maze_path_rle
    import maze_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    maze_path_rle_if.slave  bus
);

    state_t           state_q, state_d;
    logic             start, emit, emit_last;
    logic [1:0]       dir_q;
    logic [RUN_W-1:0] cnt_q;
    logic             pos_bad;

    logic             ov_q, ol_q, oerr_q;
    logic [1:0]       od_q;
    logic [RUN_W-1:0] orun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FLUSH may take the first step of the next path in the same cycle the last run is shown.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                start   = 1'b1;
                state_d = RUN;
            end
            RUN: if (bus.in_valid) begin
                emit = (bus.in != dir_q);
            end else begin
                emit      = 1'b1;
                emit_last = 1'b1;
                state_d   = FLUSH;
            end
            FLUSH: if (bus.in_valid) begin
                start   = 1'b1;
                state_d = RUN;
            end else begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q  <= '0;
            cnt_q  <= '0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            orun_q <= '0;
            ol_q   <= 1'b0;
            oerr_q <= 1'b0;
        end else begin
            ov_q   <= emit;
            od_q   <= emit ? dir_q : '0;
            orun_q <= emit ? cnt_q : '0;
            ol_q   <= emit_last;
            oerr_q <= emit_last & pos_bad;
            if (start || (emit && !emit_last)) begin
                dir_q <= bus.in;
                cnt_q <= RUN_W'(1);
            end else if (bus.in_valid && cnt_q != '1) begin
                cnt_q <= cnt_q + RUN_W'(1);
            end
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_dir   = od_q;
    assign bus.out_run   = orun_q;
    assign bus.out_last  = ol_q;
    assign bus.err       = oerr_q;

`ifdef MAZE_RLE_STEPCNT_EN
    logic [STEP_W-1:0] steps_q, osteps_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps_q  <= '0;
            osteps_q <= '0;
        end else begin
            osteps_q <= emit_last ? steps_q : '0;
            if (start)
                steps_q <= STEP_W'(1);
            else if (bus.in_valid && steps_q != '1)
                steps_q <= steps_q + STEP_W'(1);
        end
    end

    assign bus.out_steps = osteps_q;
`endif

    maze_pos_tracker u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (bus.in_valid),
        .first (start),
        .dir   (bus.in),
        .bad   (pos_bad)
    );

endmodule

// File: tb/tb_maze_path_rle.sv
// tb/tb_maze_path_rle.sv - self-checking bench for maze_path_rle against a path-level reference model
module tb_maze_path_rle;
    import maze_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    maze_path_rle_if bus();

    maze_path_rle dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] dir;
        logic [4:0] run;
        logic       last;
        logic       err;
        logic [8:0] steps;
        int         cyc;
    } rec_t;

    typedef struct {
        int         pat;
        int         exp_pulses;
        logic       exp_err;
        logic [1:0] exp_ldir;
        logic [4:0] exp_lrun;
        logic [8:0] exp_steps;
    } vec_t;

    rec_t exp_q[$];
    rec_t got_q[$];
    rec_t mon_r;
    rec_t lastg;
    int   ng;
    int   total = 0;
    int   bad   = 0;
    int   ecount = 0;

    always @(posedge clk) ecount <= ecount + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                mon_r.dir  = bus.out_dir;
                mon_r.run  = bus.out_run;
                mon_r.last = bus.out_last;
                mon_r.err  = bus.err;
`ifdef MAZE_RLE_STEPCNT_EN
                mon_r.steps = bus.out_steps;
`else
                mon_r.steps = '0;
`endif
                mon_r.cyc  = ecount;
                got_q.push_back(mon_r);
            end else begin
                total++;
                if ({bus.out_dir, bus.out_run, bus.out_last, bus.err} !== 9'd0) begin
                    bad++;
                    $display("FAIL idle_zero cyc=%0d got dir=%0d run=%0d last=%0b err=%0b want all 0",
                             ecount, bus.out_dir, bus.out_run, bus.out_last, bus.err);
                end
            end
        end
    end

    // Reference: walk the path with integers and group equal neighbouring directions.
    function automatic void model(input logic [1:0] d[$], input int base);
        int r = 0, c = 0, run = 0;
        bit e = 0;
        rec_t x;
        for (int i = 0; i < d.size(); i++) begin
            case (d[i])
                2'd0: c++;
                2'd1: r++;
                2'd2: c--;
                default: r--;
            endcase
            if (r < 0 || r > MAZE_MAX || c < 0 || c > MAZE_MAX) e = 1;
            run++;
            if (i == d.size() - 1 || d[i+1] != d[i]) begin
                x.dir  = d[i];
                x.run  = 5'((run > 31) ? 31 : run);
                x.last = (i == d.size() - 1);
                x.err  = x.last && (e || r != MAZE_MAX || c != MAZE_MAX);
`ifdef MAZE_RLE_STEPCNT_EN
                x.steps = x.last ? 9'(d.size()) : 9'd0;
`else
                x.steps = 9'd0;
`endif
                x.cyc  = base + i + 2;
                exp_q.push_back(x);
                run = 0;
            end
        end
    endfunction

    task automatic drive_path(input logic [1:0] d[$], input int gap);
        model(d, ecount);
        for (int i = 0; i < d.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in       = d[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.in = 2'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all(input string name);
        int n;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s pulse_count got=%0d want=%0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_q[i].dir !== exp_q[i].dir || got_q[i].run !== exp_q[i].run ||
                got_q[i].last !== exp_q[i].last || got_q[i].err !== exp_q[i].err ||
                got_q[i].steps !== exp_q[i].steps || got_q[i].cyc != exp_q[i].cyc) begin
                bad++;
                $display("FAIL %s rec%0d got dir=%0d run=%0d last=%0b err=%0b steps=%0d cyc=%0d want dir=%0d run=%0d last=%0b err=%0b steps=%0d cyc=%0d",
                         name, i, got_q[i].dir, got_q[i].run, got_q[i].last, got_q[i].err, got_q[i].steps, got_q[i].cyc,
                         exp_q[i].dir, exp_q[i].run, exp_q[i].last, exp_q[i].err, exp_q[i].steps, exp_q[i].cyc);
            end
        end
        ng = got_q.size();
        if (ng > 0) lastg = got_q[ng-1];
        else lastg = '{dir: 2'd0, run: 5'd0, last: 1'b0, err: 1'b0, steps: 9'd0, cyc: 0};
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic void make_pat(input int p, output logic [1:0] d[$]);
        d.delete();
        case (p)
            0: begin
                repeat (16) d.push_back(2'd0);
                repeat (16) d.push_back(2'd1);
            end
            1: repeat (16) begin d.push_back(2'd0); d.push_back(2'd1); end
            2: begin
                d.push_back(2'd3);
                d.push_back(2'd1);
                repeat (16) d.push_back(2'd0);
                repeat (16) d.push_back(2'd1);
            end
            3: begin
                repeat (16) d.push_back(2'd1);
                repeat (15) d.push_back(2'd0);
            end
            4: repeat (40) d.push_back(2'd0);
            default: d.push_back(2'd0);
        endcase
    endfunction

    vec_t        tbl[8];
    logic [1:0]  d[$];
    logic [1:0]  tmp;

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{pat: 0, exp_pulses: 2,  exp_err: 1'b0, exp_ldir: 2'd1, exp_lrun: 5'd16, exp_steps: 9'd32};
        tbl[1] = '{pat: 1, exp_pulses: 32, exp_err: 1'b0, exp_ldir: 2'd1, exp_lrun: 5'd1,  exp_steps: 9'd32};
        tbl[2] = '{pat: 2, exp_pulses: 4,  exp_err: 1'b1, exp_ldir: 2'd1, exp_lrun: 5'd16, exp_steps: 9'd34};
        tbl[3] = '{pat: 0, exp_pulses: 2,  exp_err: 1'b0, exp_ldir: 2'd1, exp_lrun: 5'd16, exp_steps: 9'd32};
        tbl[4] = '{pat: 3, exp_pulses: 2,  exp_err: 1'b1, exp_ldir: 2'd0, exp_lrun: 5'd15, exp_steps: 9'd31};
        tbl[5] = '{pat: 4, exp_pulses: 1,  exp_err: 1'b1, exp_ldir: 2'd0, exp_lrun: 5'd31, exp_steps: 9'd40};
        tbl[6] = '{pat: 5, exp_pulses: 1,  exp_err: 1'b1, exp_ldir: 2'd0, exp_lrun: 5'd1,  exp_steps: 9'd1};
        tbl[7] = '{pat: 0, exp_pulses: 2,  exp_err: 1'b0, exp_ldir: 2'd1, exp_lrun: 5'd16, exp_steps: 9'd32};

        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in       = 2'd0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.out_dir, bus.out_run, bus.out_last, bus.err} !== 10'd0) begin
            bad++;
            $display("FAIL reset_no_clock got=%0h want=0",
                     {bus.out_valid, bus.out_dir, bus.out_run, bus.out_last, bus.err});
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a path must drop it silently.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = 2'd0;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.out_dir, bus.out_run, bus.out_last, bus.err} !== 10'd0) begin
            bad++;
            $display("FAIL reset_mid_path got=%0h want=0",
                     {bus.out_valid, bus.out_dir, bus.out_run, bus.out_last, bus.err});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("after_reset");

        for (int v = 0; v < 8; v++) begin
            make_pat(tbl[v].pat, d);
            drive_path(d, 1);
            check_all($sformatf("vec%0d", v));
            total++;
            if (ng != tbl[v].exp_pulses) begin
                bad++;
                $display("FAIL vec%0d pulses got=%0d want=%0d", v, ng, tbl[v].exp_pulses);
            end
            total++;
            if (lastg.last !== 1'b1 || lastg.err !== tbl[v].exp_err ||
                lastg.dir !== tbl[v].exp_ldir || lastg.run !== tbl[v].exp_lrun) begin
                bad++;
                $display("FAIL vec%0d final got dir=%0d run=%0d last=%0b err=%0b want dir=%0d run=%0d last=1 err=%0b",
                         v, lastg.dir, lastg.run, lastg.last, lastg.err,
                         tbl[v].exp_ldir, tbl[v].exp_lrun, tbl[v].exp_err);
            end
`ifdef MAZE_RLE_STEPCNT_EN
            total++;
            if (lastg.steps !== tbl[v].exp_steps) begin
                bad++;
                $display("FAIL vec%0d steps got=%0d want=%0d", v, lastg.steps, tbl[v].exp_steps);
            end
`endif
        end

        // Random paths, mostly back-to-back with a single idle cycle between them.
        for (int k = 0; k < 40; k++) begin
            d.delete();
            if ($urandom_range(1, 0) == 1) begin
                repeat (16) d.push_back(2'd0);
                repeat (16) d.push_back(2'd1);
                for (int i = 31; i > 0; i--) begin
                    int j;
                    j = $urandom_range(i, 0);
                    tmp  = d[i];
                    d[i] = d[j];
                    d[j] = tmp;
                end
            end else begin
                repeat ($urandom_range(40, 1)) d.push_back(2'($urandom));
            end
            drive_path(d, ($urandom_range(3, 0) == 0) ? 2 : 1);
            if (k % 4 == 3) check_all($sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
